// File: rtl/spi_ram_pkg.sv
// Shared types and default sizing for the spi_ram command decoder and its memory core.
// Optional feature macro used by the design: RAM_AUTO_INC_EN.
package spi_ram_pkg;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } ram_cmd_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_HOLD = 1'b1
  } ram_state_e;

endpackage

// File: rtl/spram_core.sv
// Single-port RAM array: synchronous write with enable, registered read with enable.
// The array itself is never reset; only the read data register is.
module spram_core
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem_r [MEM_DEPTH];
  logic [7:0] rdata_r;

  // Memory array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read data register; holds its value until the next read enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 8'h00;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/spi_ram.sv
// Command decoder, rx_valid edge detector and read-hold FSM in front of spram_core.
// Build option: define RAM_AUTO_INC_EN for post-access address auto-increment.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  logic                 rx_valid_q_r;
  logic                 accept_s;
  ram_cmd_e             cmd_s;
  logic                 we_s;
  logic                 re_s;
  logic [ADDR_SIZE-1:0] wr_addr_r;
  logic [ADDR_SIZE-1:0] rd_addr_r;
  logic [ADDR_SIZE-1:0] raddr_s;
  logic                 rd_addr_set_r;
  ram_state_e           state_r;
  logic                 tx_valid_r;

  // Command accept (rising edge of rx_valid) and memory enable decode.
  always_comb begin
    accept_s = rx_valid & ~rx_valid_q_r;
    cmd_s    = ram_cmd_e'(din[9:8]);
    we_s     = 1'b0;
    re_s     = 1'b0;
    if (accept_s) begin
      case (cmd_s)
        WR_DATA: we_s = 1'b1;
        RD_DATA: re_s = 1'b1;
        default: begin
          we_s = 1'b0;
          re_s = 1'b0;
        end
      endcase
    end else begin
      we_s = 1'b0;
      re_s = 1'b0;
    end
    // Before any read address arrives the read pointer is defined to be 0.
    raddr_s = rd_addr_set_r ? rd_addr_r : {ADDR_SIZE{1'b0}};
  end

  // Edge-detect register and address pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q_r  <= 1'b0;
      wr_addr_r     <= {ADDR_SIZE{1'b0}};
      rd_addr_r     <= {ADDR_SIZE{1'b0}};
      rd_addr_set_r <= 1'b0;
    end else begin
      rx_valid_q_r <= rx_valid;
      if (accept_s) begin
        case (cmd_s)
          WR_ADDR: wr_addr_r <= din[ADDR_SIZE-1:0];
          RD_ADDR: begin
            rd_addr_r     <= din[ADDR_SIZE-1:0];
            rd_addr_set_r <= 1'b1;
          end
`ifdef RAM_AUTO_INC_EN
          WR_DATA: wr_addr_r <= wr_addr_r + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
          RD_DATA: rd_addr_r <= raddr_s + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
`endif
          default: begin
            wr_addr_r <= wr_addr_r;
            rd_addr_r <= rd_addr_r;
          end
        endcase
      end
    end
  end

  // Read-hold FSM with registered tx_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tx_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (re_s) begin
            state_r    <= RD_HOLD;
            tx_valid_r <= 1'b1;
          end
        end
        RD_HOLD: begin
          if (re_s) begin
            state_r    <= RD_HOLD;
            tx_valid_r <= 1'b1;
          end else if (accept_s || !rx_valid) begin
            state_r    <= IDLE;
            tx_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          tx_valid_r <= 1'b0;
        end
      endcase
    end
  end

  spram_core #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (wr_addr_r),
    .wdata (din[7:0]),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (dout)
  );

  assign tx_valid = tx_valid_r;

endmodule

// File: tb/tb_spi_ram.sv
// Randomized self-checking bench for spi_ram against an array-based command model.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  int n_cmp = 0;
  int n_err = 0;

  int m_mem [256];
  int m_wr;
  int m_rd;
  int m_dout;

  spi_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr   = 0;
    m_rd   = 0;
    m_dout = 0;
  endtask

  // One command: raise rx_valid for 'hold' cycles, then drop it for one cycle.
  task automatic do_cmd(input int op, input int pl, input int hold);
    @(negedge clk);
    din      = 10'(op * 256 + pl);
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    case (op)
      0: m_wr = pl;
      1: begin
        m_mem[m_wr] = pl;
`ifdef RAM_AUTO_INC_EN
        m_wr = (m_wr + 1) % 256;
`endif
      end
      2: m_rd = pl;
      default: begin
        m_dout = m_mem[m_rd];
`ifdef RAM_AUTO_INC_EN
        m_rd = (m_rd + 1) % 256;
`endif
      end
    endcase
    if (op == 3) begin
      check("rd_tx_valid", {31'd0, tx_valid}, 32'd1);
      check("rd_dout", {24'd0, dout}, m_dout);
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      din = 10'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      if (op == 3) check("hold_tx_valid", {31'd0, tx_valid}, 32'd1);
      check("hold_dout", {24'd0, dout}, m_dout);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("release_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("release_dout", {24'd0, dout}, m_dout);
  endtask

  initial begin
    rst_n    = 1'b0;
    din      = 10'd0;
    rx_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_dout", {24'd0, dout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole array so every later read has a known expected value.
    for (int a = 0; a < 256; a++) begin
      do_cmd(0, a, 1);
      do_cmd(1, int'($urandom_range(0, 255)), 1);
    end

    // Reset while in RD_HOLD, then read without a read address.
    do_cmd(2, 8'h42, 1);
    @(negedge clk);
    din      = 10'h300;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("pre_rst_dout", {24'd0, dout}, m_mem[8'h42]);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("async_rst_dout", {24'd0, dout}, 32'd0);
    rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(3, 0, 3);
    check("read_mem0_after_reset", {24'd0, dout}, m_mem[0]);

    // Directed write then read back.
    do_cmd(0, 8'h3A, 1);
    do_cmd(1, 8'hC5, 1);
    do_cmd(2, 8'h3A, 1);
    do_cmd(3, 8'h00, 2);
    check("wr_rd_C5", {24'd0, dout}, 32'h0000_00C5);

    // Held rx_valid writes exactly once, din changes mid-hold are ignored.
    do_cmd(0, 8'h10, 1);
    do_cmd(1, 8'hAA, 12);
    do_cmd(2, 8'h10, 1);
    do_cmd(3, 8'h00, 1);
    check("held_write_once", {24'd0, dout}, 32'h0000_00AA);

    // tx_valid release after a 9-cycle hold.
    do_cmd(3, 8'h00, 9);

    // Back-to-back reads at 0x05 and 0x06.
    do_cmd(2, 8'h05, 1);
    do_cmd(3, 8'h00, 2);
    check("b2b_first", {24'd0, dout}, m_mem[5]);
    do_cmd(2, 8'h06, 1);
    do_cmd(3, 8'h00, 2);
    check("b2b_second", {24'd0, dout}, m_mem[6]);

    // Address wrap with optional auto-increment.
    do_cmd(0, 8'hFF, 1);
    do_cmd(1, 8'h11, 1);
    do_cmd(1, 8'h22, 1);
    do_cmd(2, 8'hFF, 1);
    do_cmd(3, 8'h00, 1);
`ifdef RAM_AUTO_INC_EN
    check("wrap_memFF", {24'd0, dout}, 32'h0000_0011);
    do_cmd(2, 8'h00, 1);
    do_cmd(3, 8'h00, 1);
    check("wrap_mem00", {24'd0, dout}, 32'h0000_0022);
`else
    check("wrap_memFF", {24'd0, dout}, 32'h0000_0022);
`endif

    // Random command stream against the model.
    for (int n = 0; n < 300; n++) begin
      do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
             int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
